// File: rtl/seq_mult_unit_if.sv
// Issue/result bundle between the control logic and the shift-add multiplier unit.
// The issuer drives the operands and start; the unit returns busy, done and the product.
interface seq_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               is_signed;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: shift-add sequential multiplier (one multiplier bit per cycle), signed or unsigned per operation.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_sh_r;
    logic [WIDTH-1:0]   mplr_sh_r;
    logic               neg_flag_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0]   mplr_next_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               last_iter_s;

    // Absolute value of a signed operand; -2^(W-1) maps to 2^(W-1), still representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    // Next accumulator/multiplier values and the CALC exit condition.
    always_comb begin
        mplr_next_s = mplr_sh_r >> 1'b1;
        acc_next_s  = mplr_sh_r[0] ? (acc_r + mcand_sh_r) : acc_r;
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_iter_s = (cnt_r == CNT_W'(WIDTH - 1)) || (mplr_next_s == {WIDTH{1'b0}});
`else
        last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
`endif
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            acc_r      <= '0;
            mcand_sh_r <= '0;
            mplr_sh_r  <= '0;
            neg_flag_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            product_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mcand_sh_r <= {{WIDTH{1'b0}}, magnitude(bus.multiplicand, bus.is_signed)};
                        mplr_sh_r  <= magnitude(bus.multiplier, bus.is_signed);
                        neg_flag_r <= bus.is_signed &
                                      (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        busy_r     <= 1'b1;
                        state_r    <= CALC;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                CALC: begin
                    acc_r      <= acc_next_s;
                    mcand_sh_r <= mcand_sh_r << 1'b1;
                    mplr_sh_r  <= mplr_next_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
                    state_r    <= last_iter_s ? FIX : CALC;
                end
                FIX: begin
                    // Two's-complement negate of zero stays zero, so no special case is needed.
                    product_r <= neg_flag_r ? (-acc_r) : acc_r;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed self-checking bench for seq_mult_unit at WIDTH=32; expected latencies follow SEQ_MULT_EARLY_TERM_EN.
module tb_seq_mult_unit;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    seq_mult_unit_if #(.WIDTH(W)) bus ();

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else passed++;
        total++; if (bus.product !== 64'h0) $display("FAIL reset_product got=%h want=0", bus.product); else passed++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", bus.busy); else passed++;
    endtask

    // Full operation: accept at edge 0, done expected after edge exp_lat, then a single-cycle pulse.
    task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input int lat_et);
        int   exp_lat;
        int   n;
        logic busy_ok;
`ifdef SEQ_MULT_EARLY_TERM_EN
        exp_lat = lat_et;
`else
        exp_lat = W + 1;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = sgn; bus.multiplicand = a; bus.multiplier = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.is_signed = ~sgn;
        bus.multiplicand = 32'hA5A5_A5A5; bus.multiplier = 32'h5A5A_5A5A;
        total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL %s_accept busy=%b done=%b want busy=1 done=0", name, bus.busy, bus.done); else passed++;
        n = 0; busy_ok = 1'b1;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.done === 1'b1) break;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        total++; if (n != exp_lat) $display("FAIL %s_latency got=%0d want=%0d", name, n, exp_lat); else passed++;
        total++; if (busy_ok !== 1'b1) $display("FAIL %s_busy_hold got=0 want=1", name); else passed++;
        total++; if (bus.product !== exp_p) $display("FAIL %s_product got=%h want=%h", name, bus.product, exp_p); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL %s_busy_at_done got=%b want=0", name, bus.busy); else passed++;
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0 || bus.product !== exp_p)
            $display("FAIL %s_pulse_hold done=%b product=%h want done=0 product=%h", name, bus.done, bus.product, exp_p);
        else passed++;
    endtask

    task automatic test_unsigned();
        run_op("u_max",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
        run_op("u_msb_x2", 1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 3);
        run_op("u_5_msb",  1'b0, 32'h0000_0005, 32'h8000_0000, 64'h0000_0002_8000_0000, 33);
        run_op("u_5x1",    1'b0, 32'h0000_0005, 32'h0000_0001, 64'h0000_0000_0000_0005, 2);
        run_op("u_5x0",    1'b0, 32'h0000_0005, 32'h0000_0000, 64'h0000_0000_0000_0000, 2);
    endtask

    task automatic test_signed();
        run_op("s_m3x7",   1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 4);
        run_op("s_minsq",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
        run_op("s_min_x2", 1'b1, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000, 3);
        run_op("s_0xm1",   1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 2);
        run_op("s_7xm1",   1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 2);
    endtask

    // A second start raised while busy must be dropped: one done, product of the first pair.
    task automatic test_ignored_start();
        int inj;
        int dones;
        logic [2*W-1:0] seen;
`ifdef SEQ_MULT_EARLY_TERM_EN
        inj = 2;
`else
        inj = 10;
`endif
        dones = 0; seen = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.multiplicand = 32'd5; bus.multiplier = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            if (e == inj) begin
                bus.start = 1'b1; bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
            end
            @(posedge clk); #1;
            if (e == inj) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                seen = bus.product;
            end
        end
        total++; if (dones != 1) $display("FAIL ign_done_count got=%0d want=1", dones); else passed++;
        total++; if (seen !== 64'd30) $display("FAIL ign_product got=%h want=%h", seen, 64'd30); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL ign_idle_busy got=%b want=0", bus.busy); else passed++;
    endtask

    // start held from the done edge onward: rejected in DONE, accepted on the following IDLE edge.
    task automatic test_back_to_back();
        int n;
        int exp_lat;
`ifdef SEQ_MULT_EARLY_TERM_EN
        exp_lat = 5;
`else
        exp_lat = W + 1;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.multiplicand = 32'd3; bus.multiplier = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.done === 1'b1) break;
        end
        total++; if (bus.product !== 64'd12) $display("FAIL b2b_first got=%h want=%h", bus.product, 64'd12); else passed++;
        bus.start = 1'b1; bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL b2b_done_reject busy=%b want=0", bus.busy); else passed++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL b2b_idle_accept busy=%b want=1", bus.busy); else passed++;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (bus.done === 1'b1) break;
        end
        total++; if (n != exp_lat) $display("FAIL b2b_latency got=%0d want=%0d", n, exp_lat); else passed++;
        total++; if (bus.product !== 64'd81) $display("FAIL b2b_second got=%h want=%h", bus.product, 64'd81); else passed++;
        @(posedge clk); #1;
    endtask

    // Asynchronous reset at edge 15 aborts the operation without a done pulse.
    task automatic test_reset_mid_op();
        logic stray;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0;
        bus.multiplicand = 32'hFFFF_FFFF; bus.multiplier = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
        end
        #1;
        total++; if (bus.busy !== 1'b1) $display("FAIL rst_pre_busy got=%b want=1", bus.busy); else passed++;
        rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0)
            $display("FAIL rst_async busy=%b done=%b product=%h want all 0", bus.busy, bus.done, bus.product);
        else passed++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        total++; if (stray !== 1'b0) $display("FAIL rst_no_done got=1 want=0"); else passed++;
        run_op("post_rst", 1'b0, 32'd6, 32'd7, 64'd42, 4);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
